// File: rtl/mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe
//   MEM/WB pipeline register of a 5-stage MIPS pipeline. Captures the MEM-stage
//   results and control on every rising clock edge and presents them to the
//   WB stage one cycle later. op_out is the select of the downstream JAL
//   writeback muxes and link_out (PC+8) is their link-data input.
//
//   Edge priority: rst (asynchronous) > flush > stall > load.
//     flush          : stage becomes a bubble (all payload/control zero)
//     stall          : every output, including retire_cnt, holds
//     load, !valid   : bubble, retire_cnt unchanged
//     load, valid    : capture inputs, link = pc4 + 4, retire_cnt + 1
//
//   Ports
//     clk, rst                  clock, asynchronous active-high reset
//     stall, flush              pipeline control
//     in_valid                  MEM stage holds a real instruction
//     op_in, regwrite_in,
//     memtoreg_in, alu_in,
//     mem_in, pc4_in, rd_in     MEM-stage results and control
//     valid_out, op_out,
//     regwrite_out, memtoreg_out,
//     alu_out, mem_out,
//     link_out, rd_out          registered WB-stage view
//     retire_cnt                instructions that have entered WB
//
//   Every output comes straight from a flop; there is no combinational path
//   from any input to any output.
// ---------------------------------------------------------------------------
module mem_wb_pipe #(
    parameter int         bitwidth = 32,
    parameter logic [5:0] JAL_OP   = 6'b000011
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [5:0]          op_in,
    input  logic                regwrite_in,
    input  logic                memtoreg_in,
    input  logic [bitwidth-1:0] alu_in,
    input  logic [bitwidth-1:0] mem_in,
    input  logic [bitwidth-1:0] pc4_in,
    input  logic [4:0]          rd_in,
    output logic                valid_out,
    output logic [5:0]          op_out,
    output logic                regwrite_out,
    output logic                memtoreg_out,
    output logic [bitwidth-1:0] alu_out,
    output logic [bitwidth-1:0] mem_out,
    output logic [bitwidth-1:0] link_out,
    output logic [4:0]          rd_out,
    output logic [31:0]         retire_cnt
);

    // PC+4 -> PC+8; the carry out of the top bit is deliberately dropped so
    // the link value wraps modulo 2^bitwidth.
    function automatic logic [bitwidth-1:0] link_addr(input logic [bitwidth-1:0] pc4);
        logic [bitwidth-1:0] four;
        four = {{(bitwidth-3){1'b0}}, 3'b100};
        return pc4 + four;
    endfunction

    // Writes to $zero are dropped, except for JAL: its rd field is 0 but the
    // writeback mux retargets the write to $31, so the enable must survive.
    function automatic logic gated_regwrite(input logic       regwrite,
                                            input logic [4:0] rd,
                                            input logic [5:0] op);
        logic rd_is_zero;
        logic is_jal;
        rd_is_zero = (rd == 5'd0);
        is_jal     = (op == JAL_OP);
        return regwrite & ~(rd_is_zero & ~is_jal);
    endfunction

    logic                valid_q,    valid_d;
    logic [5:0]          op_q,       op_d;
    logic                regwrite_q, regwrite_d;
    logic                memtoreg_q, memtoreg_d;
    logic [bitwidth-1:0] alu_q,      alu_d;
    logic [bitwidth-1:0] mem_q,      mem_d;
    logic [bitwidth-1:0] link_q,     link_d;
    logic [4:0]          rd_q,       rd_d;
    logic [31:0]         retire_cnt_q, retire_cnt_d;

    logic                load_s;
    logic                retire_s;

    // Decode the edge action: a load happens only when neither flush nor
    // stall is active; a retirement is a load of a real instruction.
    always_comb begin
        load_s   = ~flush & ~stall;
        retire_s = load_s & in_valid;
    end

    // Next-state for the stage payload and control.
    always_comb begin
        valid_d    = valid_q;
        op_d       = op_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        alu_d      = alu_q;
        mem_d      = mem_q;
        link_d     = link_q;
        rd_d       = rd_q;
        if (flush || (load_s && !in_valid)) begin
            // Bubble: op_d=0 also steers the JAL muxes to their normal input.
            valid_d    = 1'b0;
            op_d       = 6'd0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            alu_d      = {bitwidth{1'b0}};
            mem_d      = {bitwidth{1'b0}};
            link_d     = {bitwidth{1'b0}};
            rd_d       = 5'd0;
        end else if (retire_s) begin
            valid_d    = 1'b1;
            op_d       = op_in;
            regwrite_d = gated_regwrite(regwrite_in, rd_in, op_in);
            memtoreg_d = memtoreg_in;
            alu_d      = alu_in;
            mem_d      = mem_in;
            link_d     = link_addr(pc4_in);
            rd_d       = rd_in;
        end else begin
            // Stall: keep everything (defaults already hold the state).
            valid_d    = valid_q;
        end
    end

    // Next-state for the retired-instruction counter (wraps naturally).
    always_comb begin
        if (retire_s) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            op_q         <= 6'd0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            alu_q        <= {bitwidth{1'b0}};
            mem_q        <= {bitwidth{1'b0}};
            link_q       <= {bitwidth{1'b0}};
            rd_q         <= 5'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            valid_q      <= valid_d;
            op_q         <= op_d;
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
            alu_q        <= alu_d;
            mem_q        <= mem_d;
            link_q       <= link_d;
            rd_q         <= rd_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign valid_out    = valid_q;
    assign op_out       = op_q;
    assign regwrite_out = regwrite_q;
    assign memtoreg_out = memtoreg_q;
    assign alu_out      = alu_q;
    assign mem_out      = mem_q;
    assign link_out     = link_q;
    assign rd_out       = rd_q;
    assign retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_pipe
//   Randomized plus directed stimulus against a reference model of the
//   MEM/WB register. The driver updates the model as it drives each edge and
//   queues the expected WB view; a monitor pops one entry after every rising
//   edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_mem_wb_pipe;

    localparam logic [5:0] JAL = 6'b000011;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [5:0]  op_in;
    logic        regwrite_in;
    logic        memtoreg_in;
    logic [31:0] alu_in;
    logic [31:0] mem_in;
    logic [31:0] pc4_in;
    logic [4:0]  rd_in;
    logic        valid_out;
    logic [5:0]  op_out;
    logic        regwrite_out;
    logic        memtoreg_out;
    logic [31:0] alu_out;
    logic [31:0] mem_out;
    logic [31:0] link_out;
    logic [4:0]  rd_out;
    logic [31:0] retire_cnt;

    mem_wb_pipe #(.bitwidth(32), .JAL_OP(JAL)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .op_in(op_in), .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
        .alu_in(alu_in), .mem_in(mem_in), .pc4_in(pc4_in), .rd_in(rd_in),
        .valid_out(valid_out), .op_out(op_out), .regwrite_out(regwrite_out),
        .memtoreg_out(memtoreg_out), .alu_out(alu_out), .mem_out(mem_out),
        .link_out(link_out), .rd_out(rd_out), .retire_cnt(retire_cnt)
    );

    typedef struct packed {
        logic        v;
        logic [5:0]  op;
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] link;
        logic [4:0]  rd;
        logic [31:0] cnt;
    } wb_t;

    wb_t st;          // reference model state (what WB should show)
    wb_t exp_q[$];    // one entry per rising edge after reset release
    int  n_cmp  = 0;
    int  n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wb_t dut_view();
        return '{valid_out, op_out, regwrite_out, memtoreg_out,
                 alu_out, mem_out, link_out, rd_out, retire_cnt};
    endfunction

    // Reference model: what the WB stage holds after one edge.
    function automatic wb_t model_step(input wb_t cur, input logic s, input logic f,
                                       input logic v, input logic [5:0] op,
                                       input logic rw, input logic m2r,
                                       input logic [31:0] alu, input logic [31:0] mem,
                                       input logic [31:0] pc4, input logic [4:0] rd);
        wb_t nxt;
        nxt = cur;
        if (f || (!s && !v)) begin
            nxt     = '0;
            nxt.cnt = cur.cnt;
        end else if (!s) begin
            nxt.v    = 1'b1;
            nxt.op   = op;
            nxt.rw   = rw && !(rd == 5'd0 && op != JAL);
            nxt.m2r  = m2r;
            nxt.alu  = alu;
            nxt.mem  = mem;
            nxt.link = pc4 + 32'd4;
            nxt.rd   = rd;
            nxt.cnt  = cur.cnt + 32'd1;
        end
        return nxt;
    endfunction

    // Drive inputs for the coming edge (call only at a negedge) and queue
    // the expected result of that edge.
    task automatic drive_now(input logic s, input logic f, input logic v,
                             input logic [5:0] op, input logic rw, input logic m2r,
                             input logic [31:0] alu, input logic [31:0] mem,
                             input logic [31:0] pc4, input logic [4:0] rd);
        stall = s; flush = f; in_valid = v; op_in = op; regwrite_in = rw;
        memtoreg_in = m2r; alu_in = alu; mem_in = mem; pc4_in = pc4; rd_in = rd;
        st = model_step(st, s, f, v, op, rw, m2r, alu, mem, pc4, rd);
        exp_q.push_back(st);
    endtask

    task automatic apply(input logic s, input logic f, input logic v,
                         input logic [5:0] op, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc4, input logic [4:0] rd);
        @(negedge clk);
        drive_now(s, f, v, op, rw, m2r, alu, mem, pc4, rd);
    endtask

    task automatic apply_rand();
        logic       s, f, v, rw, m2r;
        logic [5:0] op;
        logic [4:0] rd;
        s   = ($urandom_range(0, 3) == 0);
        f   = ($urandom_range(0, 9) == 0);
        v   = ($urandom_range(0, 3) != 0);
        op  = ($urandom_range(0, 3) == 0) ? JAL : 6'($urandom_range(0, 63));
        rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rw  = 1'($urandom_range(0, 1));
        m2r = 1'($urandom_range(0, 1));
        apply(s, f, v, op, rw, m2r, $urandom, $urandom, $urandom, rd);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any edge.
    task automatic async_reset_check();
        wb_t a;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        a = dut_view();
        n_cmp++;
        if (a !== '0) begin
            n_fail++;
            $display("FAIL async_reset t=%0t got=%h required=0", $time, a);
        end
        st = '0;
        @(negedge clk);
        rst = 1'b0;
        drive_now(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    // Monitor: compare the DUT against the queued expectation after each edge.
    initial begin : monitor
        wb_t e;
        wb_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = dut_view();
                n_cmp++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL wb_outputs t=%0t got=%h required=%h", $time, a, e);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; op_in = 6'd0;
        regwrite_in = 1'b0; memtoreg_in = 1'b0; alu_in = 32'd0; mem_in = 32'd0;
        pc4_in = 32'd0; rd_in = 5'd0;
        st = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (dut_view() !== '0) begin
            n_fail++;
            $display("FAIL reset_state got=%h required=0", dut_view());
        end
        rst = 1'b0;
        drive_now(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);

        // JAL with rd=0 keeps regwrite; link = pc4 + 4.
        apply(1'b0, 1'b0, 1'b1, JAL, 1'b1, 1'b0, 32'h11, 32'h22, 32'h0040_0010, 5'd0);
        // R-type writing $zero: regwrite suppressed, still valid, counts.
        apply(1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 32'h33, 32'h44, 32'h0040_0014, 5'd0);
        // Load alu=0x1234 then stall three cycles with changing inputs.
        apply(1'b0, 1'b0, 1'b1, 6'h23, 1'b1, 1'b1, 32'h1234, 32'h5678, 32'h0040_0018, 5'd8);
        for (int i = 0; i < 3; i++)
            apply(1'b1, 1'b0, 1'b1, 6'h2b, 1'b1, 1'b0, $urandom, $urandom, $urandom, 5'd9);
        apply(1'b0, 1'b0, 1'b1, 6'h08, 1'b1, 1'b0, 32'hABCD, 32'h0, 32'h0040_0020, 5'd10);
        // Stall together with flush: flush wins.
        apply(1'b1, 1'b1, 1'b1, JAL, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, 5'd31);
        // Load with in_valid=0: bubble, count unchanged.
        apply(1'b0, 1'b0, 1'b1, 6'h0, 1'b1, 1'b0, 32'h55, 32'h66, 32'h100, 5'd3);
        apply(1'b0, 1'b0, 1'b0, 6'h0, 1'b1, 1'b0, 32'h77, 32'h88, 32'h200, 5'd4);

        async_reset_check();

        for (int i = 0; i < 300; i++) apply_rand();

        // Counter and link wrap.
        @(negedge clk);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        st.cnt = 32'hFFFF_FFFF;
        drive_now(1'b0, 1'b0, 1'b1, 6'h0, 1'b1, 1'b0, 32'h9, 32'hA, 32'hFFFF_FFFC, 5'd5);
        apply(1'b1, 1'b0, 1'b1, 6'h0, 1'b1, 1'b0, 32'h1, 32'h1, 32'h1, 5'd1);

        for (int i = 0; i < 100; i++) apply_rand();
        async_reset_check();
        for (int i = 0; i < 20; i++) apply_rand();

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain got=%0d pending required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
